// File: rtl/qam_mod_pkg.sv
// Shared types and helpers for the M-QAM modulator: FSM state, level width and Gray decode.
package qam_mod_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Signed width that holds +/-(2^B - 1) * scale.
    function automatic int lvl_width(input int b, input int scale);
        return b + $clog2(scale + 1) + 1;
    endfunction

    // Magnitude codes are at most 3 bits wide; upper zero bits decode to zero.
    function automatic logic [3:0] gray2bin(input logic [3:0] x);
        logic [3:0] b;
        b[3] = x[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ x[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/qam_level_map.sv
// Combinational per-axis mapper: sign bit plus (optionally Gray-coded) magnitude to +/-(2m+1)*SCALE.
module qam_level_map
    import qam_mod_pkg::*;
#(
    parameter int BITS_PER_AXIS = 2,
    parameter int SCALE         = 1,
    parameter int GRAY_EN       = 0,
    parameter int LVL_W         = 4
) (
    input  logic [BITS_PER_AXIS-1:0] bits,
    output logic signed [LVL_W-1:0]  level
);

    logic [3:0]              m;
    logic signed [LVL_W-1:0] mag;

    if (BITS_PER_AXIS == 1) begin : g_bpsk
        assign m = '0;
    end else begin : g_multi
        logic [3:0] code;
        assign code = 4'(bits[BITS_PER_AXIS-2:0]);
        assign m    = (GRAY_EN != 0) ? gray2bin(code) : code;
    end

    assign mag   = LVL_W'((32'(m) * 32'd2 + 32'd1) * 32'(SCALE));
    assign level = bits[BITS_PER_AXIS-1] ? -mag : mag;

endmodule

// File: rtl/qam_mod_pipe.sv
// M-QAM modulator: holds each accepted symbol for SPS carrier samples and mixes the
// I/Q levels with sin/cos through a two-stage multiply/add pipeline.
module qam_mod_pipe
    import qam_mod_pkg::*;
#(
    parameter int BITS_PER_AXIS = 2,
    parameter int CARRIER_W     = 16,
    parameter int SCALE         = 1,
    parameter int SPS           = 1,
    parameter int GRAY_EN       = 0,
    localparam int SYM_W        = 2 * BITS_PER_AXIS,
    localparam int LVL_W        = lvl_width(BITS_PER_AXIS, SCALE),
    localparam int OUT_W        = LVL_W + CARRIER_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic [SYM_W-1:0]            sym_data,
    input  logic                        sym_valid,
    output logic                        sym_ready,
    input  logic signed [CARRIER_W-1:0] sin,
    input  logic signed [CARRIER_W-1:0] cos,
    output logic signed [OUT_W-1:0]     mixed_output,
    output logic                        out_valid,
    output logic                        underflow,
    output logic                        busy
);

    localparam int PROD_W = LVL_W + CARRIER_W;
    localparam int CNT_W  = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

    state_t                    state_reg, state_next;
    logic                      stop_pend_reg, stop_pend_next;
    logic [CNT_W-1:0]          sps_cnt_reg;
    logic signed [LVL_W-1:0]   i_lvl_reg, q_lvl_reg, i_map, q_map;
    logic signed [PROD_W-1:0]  p_i_reg, p_q_reg;
    logic                      run_d1_reg;
    logic                      boundary;
    logic [BITS_PER_AXIS-1:0]  i_bits, q_bits;

    // I takes the odd bit positions, Q the even ones; MSB of each axis is its sign.
    for (genvar gi = 0; gi < BITS_PER_AXIS; gi++) begin : g_split
        assign i_bits[gi] = sym_data[2*gi+1];
        assign q_bits[gi] = sym_data[2*gi];
    end

    qam_level_map #(
        .BITS_PER_AXIS(BITS_PER_AXIS), .SCALE(SCALE), .GRAY_EN(GRAY_EN), .LVL_W(LVL_W)
    ) u_map_i (.bits(i_bits), .level(i_map));

    qam_level_map #(
        .BITS_PER_AXIS(BITS_PER_AXIS), .SCALE(SCALE), .GRAY_EN(GRAY_EN), .LVL_W(LVL_W)
    ) u_map_q (.bits(q_bits), .level(q_map));

    assign boundary = (state_reg == RUN) && (sps_cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            stop_pend_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            stop_pend_reg <= stop_pend_next;
        end
    end

    // A stop seen on a boundary cycle is only honoured at the next boundary.
    always_comb begin
        state_next     = state_reg;
        stop_pend_next = stop_pend_reg;
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (boundary && stop_pend_reg) begin
                    state_next     = IDLE;
                    stop_pend_next = 1'b0;
                end else if (stop) begin
                    stop_pend_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sym_ready = boundary && !stop_pend_reg;
        underflow = boundary && !stop_pend_reg && !sym_valid;
        busy      = (state_reg == RUN) || run_d1_reg || out_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sps_cnt_reg <= '0;
            i_lvl_reg   <= '0;
            q_lvl_reg   <= '0;
        end else if (state_reg == IDLE) begin
            if (start) begin
                sps_cnt_reg <= CNT_LAST;
                i_lvl_reg   <= '0;
                q_lvl_reg   <= '0;
            end
        end else begin
            sps_cnt_reg <= boundary ? '0 : sps_cnt_reg + CNT_W'(1);
            if (boundary) begin
                if (sym_ready && sym_valid) begin
                    i_lvl_reg <= i_map;
                    q_lvl_reg <= q_map;
                end else begin
                    i_lvl_reg <= '0;
                    q_lvl_reg <= '0;
                end
            end
        end
    end

    // Widths are sized so the products and their sum can never overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_i_reg      <= '0;
            p_q_reg      <= '0;
            mixed_output <= '0;
            run_d1_reg   <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            p_i_reg      <= PROD_W'(i_lvl_reg) * PROD_W'(sin);
            p_q_reg      <= PROD_W'(q_lvl_reg) * PROD_W'(cos);
            mixed_output <= OUT_W'(p_i_reg) + OUT_W'(p_q_reg);
            run_d1_reg   <= (state_reg == RUN);
            out_valid    <= run_d1_reg;
        end
    end

endmodule

// File: tb/tb_qam_mod_pipe.sv
// Bench for qam_mod_pipe: directed scenarios on four parameterisations, with a
// symbol-schedule model checking the SPS=4 instance on every cycle.
module tb_qam_mod_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic signed [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Instance A: defaults (16-QAM, SPS=1)
    logic rst_a = 0, start_a = 0, stop_a = 0, sym_valid_a = 0;
    logic [3:0] sym_data_a = '0;
    logic signed [15:0] sin_a = '0, cos_a = '0;
    logic sym_ready_a, out_valid_a, underflow_a, busy_a;
    logic signed [20:0] mixed_a;

    qam_mod_pipe dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .stop(stop_a),
        .sym_data(sym_data_a), .sym_valid(sym_valid_a), .sym_ready(sym_ready_a),
        .sin(sin_a), .cos(cos_a), .mixed_output(mixed_a), .out_valid(out_valid_a),
        .underflow(underflow_a), .busy(busy_a)
    );

    // Instance B: 16-QAM, SPS=4
    localparam int SPS_B = 4;
    logic rst_b = 0, start_b = 0, stop_b = 0, sym_valid_b = 0;
    logic [3:0] sym_data_b = '0;
    logic signed [15:0] sin_b = 16'sd10, cos_b = 16'sd10;
    logic sym_ready_b, out_valid_b, underflow_b, busy_b;
    logic signed [20:0] mixed_b;

    qam_mod_pipe #(.SPS(SPS_B)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .stop(stop_b),
        .sym_data(sym_data_b), .sym_valid(sym_valid_b), .sym_ready(sym_ready_b),
        .sin(sin_b), .cos(cos_b), .mixed_output(mixed_b), .out_valid(out_valid_b),
        .underflow(underflow_b), .busy(busy_b)
    );

    // Instances C (Gray) and D (binary): 64-QAM, SPS=1, shared inputs
    logic rst_c = 0, start_c = 0, stop_c = 0, sym_valid_c = 0;
    logic [5:0] sym_data_c = '0;
    logic signed [15:0] sin_c = '0, cos_c = '0;
    logic sym_ready_c, out_valid_c, underflow_c, busy_c;
    logic sym_ready_d, out_valid_d, underflow_d, busy_d;
    logic signed [21:0] mixed_c, mixed_d;

    qam_mod_pipe #(.BITS_PER_AXIS(3), .GRAY_EN(1)) dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .stop(stop_c),
        .sym_data(sym_data_c), .sym_valid(sym_valid_c), .sym_ready(sym_ready_c),
        .sin(sin_c), .cos(cos_c), .mixed_output(mixed_c), .out_valid(out_valid_c),
        .underflow(underflow_c), .busy(busy_c)
    );

    qam_mod_pipe #(.BITS_PER_AXIS(3), .GRAY_EN(0)) dut_d (
        .clk(clk), .rst(rst_c), .start(start_c), .stop(stop_c),
        .sym_data(sym_data_c), .sym_valid(sym_valid_c), .sym_ready(sym_ready_d),
        .sin(sin_c), .cos(cos_c), .mixed_output(mixed_d), .out_valid(out_valid_d),
        .underflow(underflow_d), .busy(busy_d)
    );

    // Amplitude of one axis from its bit field, straight from the level rule.
    function automatic int model_level(input int bits, input int nb, input int scale, input bit gray);
        int sgn;
        int m;
        int b;
        sgn = (bits >> (nb - 1)) & 1;
        m   = bits & ((1 << (nb - 1)) - 1);
        if (gray) begin
            b = m;
            for (int s = 1; s < nb; s++) b = b ^ (m >> s);
            m = b;
        end
        return (sgn != 0 ? -1 : 1) * (2 * m + 1) * scale;
    endfunction

    // Model for instance B: k counts cycles since entering RUN, boundaries at k % SPS == 0.
    bit m_run = 0;
    int m_k = 0;
    bit m_exit_set = 0;
    int m_exit_k = 0;
    int m_amp_i = 0, m_amp_q = 0;
    bit pv0 = 0, pv1 = 0;
    int pval0 = 0, pval1 = 0;
    int obs_b[$];
    int ready_cnt_b = 0, uf_cnt_b = 0;

    always @(negedge clk) begin
        bit bnd, rdy, exiting, cur_v;
        int cur_val, ib, qb;
        if (!rst_b) begin
            check("b_rst_mixed", mixed_b, 0);
            check("b_rst_out_valid", out_valid_b, 0);
            check("b_rst_ready", sym_ready_b, 0);
            check("b_rst_underflow", underflow_b, 0);
            check("b_rst_busy", busy_b, 0);
            m_run = 0; m_exit_set = 0; m_amp_i = 0; m_amp_q = 0;
            pv0 = 0; pv1 = 0; pval0 = 0; pval1 = 0;
        end else begin
            bnd     = m_run && (m_k % SPS_B == 0);
            exiting = bnd && m_exit_set && (m_k == m_exit_k);
            rdy     = bnd && !exiting;
            check("b_mixed", mixed_b, pval1);
            check("b_out_valid", out_valid_b, pv1);
            check("b_ready", sym_ready_b, rdy);
            check("b_underflow", underflow_b, rdy && !sym_valid_b);
            check("b_busy", busy_b, m_run || pv0 || pv1);
            if (out_valid_b) obs_b.push_back(int'(mixed_b));
            if (sym_ready_b) ready_cnt_b++;
            if (underflow_b) uf_cnt_b++;

            cur_v   = m_run;
            cur_val = m_run ? (m_amp_i * int'(sin_b) + m_amp_q * int'(cos_b)) : 0;
            pv1 = pv0; pval1 = pval0;
            pv0 = cur_v; pval0 = cur_val;

            if (!m_run) begin
                if (start_b) begin
                    m_run = 1; m_k = 0; m_exit_set = 0; m_amp_i = 0; m_amp_q = 0;
                end
            end else begin
                if (bnd) begin
                    if (exiting) begin
                        m_run = 0; m_exit_set = 0; m_amp_i = 0; m_amp_q = 0;
                    end else if (sym_valid_b) begin
                        ib = {30'd0, sym_data_b[3], sym_data_b[1]};
                        qb = {30'd0, sym_data_b[2], sym_data_b[0]};
                        m_amp_i = model_level(ib, 2, 1, 0);
                        m_amp_q = model_level(qb, 2, 1, 0);
                    end else begin
                        m_amp_i = 0; m_amp_q = 0;
                    end
                end
                if (!exiting && stop_b && !m_exit_set) begin
                    m_exit_set = 1;
                    m_exit_k   = (m_k / SPS_B + 1) * SPS_B;
                end
                m_k++;
            end
        end
    end

    task automatic send_b(input logic [3:0] d);
        bit done;
        done = 0;
        sym_data_b  = d;
        sym_valid_b = 1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (sym_ready_b) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        sym_valid_b = 0;
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL b_send_timeout: got no sym_ready expected accept of %b", d);
        end
    endtask

    int exp_b[17] = '{0, 20, 20, 20, 20, -60, -60, -60, -60, 0, 0, 0, 0, 20, 20, 20, 20};

    initial begin
        repeat (2) @(negedge clk);
        check("a_rst_mixed", mixed_a, 0);
        check("a_rst_out_valid", out_valid_a, 0);
        check("a_rst_ready", sym_ready_a, 0);
        check("a_rst_underflow", underflow_a, 0);
        check("a_rst_busy", busy_a, 0);
        @(posedge clk); #1;
        rst_a = 1; rst_b = 1; rst_c = 1;

        // A: symbol 1001 held valid, sin=100 cos=50 -> I=-1, Q=+3 -> 50
        @(posedge clk); #1;
        sin_a = 16'sd100; cos_a = 16'sd50; start_a = 1;
        @(posedge clk); #1;
        start_a = 0; sym_data_a = 4'b1001; sym_valid_a = 1;
        @(negedge clk);
        check("a_ready_k0", sym_ready_a, 1);
        check("a_out_valid_k0", out_valid_a, 0);
        check("a_busy_k0", busy_a, 1);
        @(negedge clk);
        check("a_underflow_k1", underflow_a, 0);
        check("a_out_valid_k1", out_valid_a, 0);
        @(negedge clk);
        check("a_out_valid_k2", out_valid_a, 1);
        check("a_mixed_k2", mixed_a, 0);
        @(negedge clk);
        check("a_mixed_k3", mixed_a, 50);
        check("a_out_valid_k3", out_valid_a, 1);
        @(negedge clk);
        check("a_mixed_k4", mixed_a, 50);
        #2 rst_a = 0;
        #1;
        check("a_async_mixed", mixed_a, 0);
        check("a_async_out_valid", out_valid_a, 0);
        check("a_async_busy", busy_a, 0);
        check("a_async_ready", sym_ready_a, 0);
        @(negedge clk);
        rst_a = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("a_post_rst_ready", sym_ready_a, 0);
            check("a_post_rst_busy", busy_a, 0);
            check("a_post_rst_mixed", mixed_a, 0);
        end

        // C/D: 001000 -> Gray I=+7 Q=+1 (80), binary I=+5 Q=+1 (60)
        @(posedge clk); #1;
        sin_c = 16'sd10; cos_c = 16'sd10; sym_data_c = 6'b001000; sym_valid_c = 1; start_c = 1;
        @(posedge clk); #1;
        start_c = 0;
        @(negedge clk);
        check("c_ready_k0", sym_ready_c, 1);
        check("d_ready_k0", sym_ready_d, 1);
        repeat (3) @(negedge clk);
        check("c_mixed_gray", mixed_c, 80);
        check("d_mixed_bin", mixed_d, 60);
        @(negedge clk);
        check("c_mixed_gray_k4", mixed_c, 80);
        check("d_mixed_bin_k4", mixed_d, 60);
        @(posedge clk); #1;
        sym_data_c = 6'b111111;
        repeat (4) @(negedge clk);
        check("c_mixed_gray_neg", mixed_c, -100);
        check("d_mixed_bin_neg", mixed_d, -140);

        // B: 0000, 1111 back to back, one withheld boundary, 0000, then stop at cnt=1
        @(posedge clk); #1;
        start_b = 1;
        @(posedge clk); #1;
        start_b = 0;
        send_b(4'b0000);
        send_b(4'b1111);
        repeat (4) begin
            @(posedge clk); #1;
        end
        send_b(4'b0000);
        @(posedge clk); #1;
        stop_b = 1;
        @(posedge clk); #1;
        stop_b = 0;
        repeat (8) @(negedge clk);
        check("b_obs_len", obs_b.size(), 17);
        for (int i = 0; i < 17; i++) begin
            if (i < obs_b.size()) check($sformatf("b_obs_%0d", i), obs_b[i], exp_b[i]);
        end
        check("b_ready_cnt", ready_cnt_b, 4);
        check("b_underflow_cnt", uf_cnt_b, 1);
        check("b_idle_busy", busy_b, 0);
        check("b_idle_mixed", mixed_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/qam_mod_pipe.md
Name: qam_mod_pipe

Overview:
- Parametrised M-QAM baseband-to-IF modulator.
- Accepts symbols over a valid/ready handshake and holds each symbol for SPS carrier samples.
- Maps each axis to signed amplitude levels, in binary or Gray order, and mixes them with externally supplied sin/cos samples through a 2-stage registered pipeline.
- Sits between the serial-to-parallel symbol packer and the DAC interface. Supersedes the fixed 16-QAM modulator; it is bit-compatible with it at default parameters.

Parameters:
- BITS_PER_AXIS, 2: bits per I/Q axis (1=QPSK, 2=16-QAM, 3=64-QAM); legal range 1..4.
- CARRIER_W, 16: signed width of sin/cos samples.
- SCALE, 1: level step D (positive integer); levels are ±(2m+1)*SCALE.
- SPS, 1: carrier samples per symbol; must be ≥1.
- GRAY_EN, 0: 1 = magnitude bits are Gray-coded; 0 = plain binary.
- Localparams:
  - SYM_W = 2*BITS_PER_AXIS
  - LVL_W = BITS_PER_AXIS + $clog2(SCALE+1) + 1
  - OUT_W = LVL_W + CARRIER_W + 1 (21 at defaults)

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; IDLE→RUN.
- stop  in  1  single-cycle pulse; requests return to IDLE at the next symbol boundary.
- sym_data  in  SYM_W  symbol bits; I = odd bit positions (MSB first), Q = even bit positions.
- sym_valid  in  1  sym_data valid.
- sym_ready  out  1  block accepts sym_data this cycle.
- sin  in  CARRIER_W  signed carrier sample for the I axis.
- cos  in  CARRIER_W  signed carrier sample for the Q axis.
- mixed_output  out  OUT_W  signed I_lvl*sin + Q_lvl*cos.
- out_valid  out  1  mixed_output valid.
- underflow  out  1  one-cycle pulse: boundary reached with no symbol available.
- busy  out  1  high in RUN or while the pipeline drains.

Behaviour:
- Reset (async, rst=0) clears the following and holds them while rst=0:
  - state=IDLE; sps_cnt=0; I_lvl=Q_lvl=0; pipeline registers=0.
  - mixed_output=0; out_valid=0; sym_ready=0; underflow=0; busy=0; stop_pend=0.
- States:
  - IDLE: sym_ready=0; stop ignored; start → RUN. On that edge, sps_cnt is loaded with SPS-1 and levels are cleared to 0.
  - RUN: start ignored; sps_cnt decrements-free counts 0..SPS-1 and wraps to 0.
- Boundary = RUN and sps_cnt==SPS-1; sym_ready=boundary && !stop_pend.
- At a boundary:
  - sym_valid=1: latch the mapped I/Q levels; they apply to carrier samples from the next cycle for exactly SPS cycles.
  - sym_valid=0 and no stop pending: levels cleared to 0 (silence), underflow pulses 1 cycle, stay in RUN.
  - stop_pend=1: levels cleared, go to IDLE, clear stop_pend; no symbol accepted.
- stop in RUN sets stop_pend. A stop arriving on the boundary cycle itself takes effect at the following boundary.
- Axis mapping for per-axis bits a[B-1:0]:
  - a[B-1] is sign (1 = negative); m = a[B-2:0], Gray-decoded first when GRAY_EN=1.
  - level = ±(2m+1)*SCALE. For B=1: level = ±SCALE.
  - Default params give 00→+1, 01→+3, 10→−1, 11→−3.
- Pipeline, with carrier sampled at cycle t:
  - Stage 1 at t+1: registers p_i = I_lvl*sin and p_q = Q_lvl*cos, each sign-extended to LVL_W+CARRIER_W.
  - Stage 2 at t+2: registers mixed_output = p_i + p_q in OUT_W. The width guarantees no overflow; no saturation.
- Latency is 2 cycles from sin/cos to mixed_output.
- out_valid is the state==RUN flag delayed by 2 cycles, so it includes silent (underflow) samples.
- busy = RUN || either valid-pipe bit set.
- After RUN→IDLE the pipeline flushes zeros. mixed_output returns to 0 two cycles after the transition and holds 0 in IDLE.
- Reset asserted mid-symbol aborts immediately: no partial output, all registers cleared asynchronously.

Decomposition:
- Package qam_mod_pkg holds:
  - State enum {IDLE, RUN}.
  - Functions lvl_width(B, SCALE) and gray2bin(x).
- One sub-module, qam_level_map: combinational per-axis mapper with parameters BITS_PER_AXIS, SCALE, GRAY_EN, LVL_W. It is instantiated twice (I and Q).

Test Plan:
- Defaults (B=2, SPS=1); start, then sym_data=4'b1001 valid, sin=100, cos=50 → I=−1, Q=+3; mixed_output=50 with out_valid, 2 cycles after the sample cycle.
- SPS=4; back-to-back symbols 4'b0000 then 4'b1111, sin=cos=10 → sym_ready high 1 cycle in 4; output 20 for 4 samples, then −60 for 4 samples.
- SPS=4; sym_valid withheld at the second boundary → underflow pulses once; 4 samples of 0 with out_valid=1; the next valid symbol is accepted at the following boundary.
- B=3, GRAY_EN=1, sym_data=6'b001000, sin=cos=10 → I=+7, Q=+1, output 80. Same with GRAY_EN=0 → I=+5, output 60.
- stop mid-symbol (SPS=4, cnt=1) → sym_ready stays 0 at the boundary; IDLE at the boundary; out_valid falls 2 cycles later; busy falls with it; mixed_output=0.
- rst asserted asynchronously between clock edges during RUN → all outputs 0 immediately. After release, start is required before sym_ready rises.
